// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for the cache system bus: line-sized reads and writes of
// eight beats each, backed by an internal line-organised array.
module sysbus_mem_responder #(
    parameter int   BUS_DATA_WIDTH = 64,
    parameter int   BUS_TAG_WIDTH  = 13,
    parameter logic WRITE_FLAG     = 1'b1,
    parameter int   MEM_LINES      = 64,
    parameter int   READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy,
    output logic [2:0]                beat_ptr
);

    localparam int BEATS = 8;
    localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQACK,
        S_WDATA,
        S_WACK,
        S_RLAT,
        S_RBEAT,
        S_RGAP
    } state_t;

    typedef logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
    line_t                      line_q, line_d;
    logic [LAT_W-1:0]           lat_q, lat_d;
    logic [2:0]                 beat_ptr_q, beat_ptr_d;
    logic                       reqack_q, reqack_d;
    logic                       respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0]  resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]   resptag_q, resptag_d;
    logic                       busy_q, busy_d;
    logic                       mem_we;
    line_t                      mem_q [MEM_LINES];

    logic is_write;
    assign is_write = (tag_q[BUS_TAG_WIDTH-1] == WRITE_FLAG);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        line_d     = line_q;
        lat_d      = lat_q;
        beat_ptr_d = beat_ptr_q;
        reqack_d   = 1'b0;
        respcyc_d  = respcyc_q;
        resp_d     = resp_q;
        resptag_d  = resptag_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                respcyc_d = 1'b0;
                if (bus_reqcyc) begin
                    // Only the line index matters; offset and high bits alias.
                    idx_d      = bus_req[6 +: IDX_W];
                    tag_d      = bus_reqtag;
                    beat_ptr_d = 3'd0;
                    reqack_d   = 1'b1;
                    state_d    = S_REQACK;
                end
            end
            S_REQACK: begin
                if (is_write) begin
                    state_d = S_WDATA;
                end else begin
                    line_d  = mem_q[idx_q];
                    lat_d   = '0;
                    state_d = S_RLAT;
                end
            end
            S_WDATA: begin
                if (bus_reqcyc) begin
                    line_d[beat_ptr_q] = bus_req;
                    reqack_d           = 1'b1;
                    state_d            = S_WACK;
                end
            end
            S_WACK: begin
                if (beat_ptr_q == 3'd7) begin
                    mem_we     = 1'b1;
                    beat_ptr_d = 3'd0;
                    state_d    = S_IDLE;
                end else begin
                    beat_ptr_d = beat_ptr_q + 3'd1;
                    state_d    = S_WDATA;
                end
            end
            S_RLAT: begin
                // Response registers are loaded on the way out so the beat is
                // visible in the first RBEAT cycle.
                if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    respcyc_d = 1'b1;
                    resp_d    = line_q[beat_ptr_q];
                    resptag_d = tag_q;
                    state_d   = S_RBEAT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_RBEAT: begin
                if (bus_respack) begin
                    respcyc_d = 1'b0;
                    if (beat_ptr_q == 3'd7) begin
                        beat_ptr_d = 3'd0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_RGAP;
                    end
                end
            end
            S_RGAP: begin
                beat_ptr_d = beat_ptr_q + 3'd1;
                respcyc_d  = 1'b1;
                resp_d     = line_q[beat_ptr_q + 3'd1];
                state_d    = S_RBEAT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tag_q      <= '0;
            line_q     <= '0;
            lat_q      <= '0;
            beat_ptr_q <= '0;
            reqack_q   <= 1'b0;
            respcyc_q  <= 1'b0;
            resp_q     <= '0;
            resptag_q  <= '0;
            busy_q     <= 1'b0;
            for (int unsigned i = 0; i < MEM_LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            lat_q      <= lat_d;
            beat_ptr_q <= beat_ptr_d;
            reqack_q   <= reqack_d;
            respcyc_q  <= respcyc_d;
            resp_q     <= resp_d;
            resptag_q  <= resptag_d;
            busy_q     <= busy_d;
            if (mem_we) begin
                mem_q[idx_q] <= line_q;
            end
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;
    assign busy        = busy_q;
    assign beat_ptr    = beat_ptr_q;

endmodule
